seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Unsigned sequential divider: the inverse operation to the team's combinational array multiplier.
- Accepts dividend and divisor through a valid/ready handshake.
- Computes quotient and remainder by restoring shift-subtract, one quotient bit per clock.
- Holds the result on a valid/ready output handshake. Sits beside the multiplier in the arithmetic datapath labs.

Parameters:
- WIDTH, 4, operand width of dividend, divisor, quotient and remainder (legal range ≥ 2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  dividend/divisor are valid.
- in_ready  out  1  block can accept operands.
- dividend  in  WIDTH  unsigned numerator.
- divisor  in  WIDTH  unsigned denominator.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer takes the result.
- quotient  out  WIDTH  floor(dividend/divisor).
- remainder  out  WIDTH  dividend mod divisor.
- div_by_zero  out  1  divisor was 0 for this result.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous, active-low.
  - When rst_n=0 at an edge: state=IDLE, out_valid=0, quotient=0, remainder=0, div_by_zero=0, step counter=0, internal regs=0.
  - in_ready is high from the first edge after reset.
  - Reset mid-CALC or mid-DONE abandons the operation. No result is produced.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - in_valid&in_ready at edge k with divisor≠0: load Q=dividend, R=0 (WIDTH+1 bits), D=divisor, count=0, go to CALC.
    - With divisor=0: go directly to DONE with quotient=all ones, remainder=dividend, div_by_zero=1. out_valid is high after edge k.
  - CALC: in_ready=0, out_valid=0. Each edge performs one step:
    - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
    - T = R' − {1'b0, D}.
    - If T[WIDTH]=0 then R=T and the new Q LSB is 1; else R=R' and the new Q LSB is 0.
    - Q shifts left, taking the new LSB. count increments.
    - On the step where count reaches WIDTH−1, latch quotient=Q_next, remainder=R_next[WIDTH-1:0], div_by_zero=0, and go to DONE.
    - out_valid is first high after edge k+WIDTH.
  - DONE: out_valid=1, in_ready=0.
    - Outputs are stable while out_ready=0.
    - On out_valid&out_ready: go to IDLE and drop out_valid next cycle. quotient/remainder keep their last values.
    - A new operand cannot be accepted in the same edge as the result handoff.
- Input handling: in_valid during CALC/DONE is ignored. Operands are captured only at the accept edge, so later changes to input pins have no effect.
- Width rules:
  - Partial remainder is WIDTH+1 bits so the subtraction borrow is its MSB.
  - The counter is clog2(WIDTH) bits and wrap is never reached.
  - Results are exact for all 2^(2·WIDTH) operand pairs.

Decomposition:
- Shared package holds:
  - state encoding localparams IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - the clog2 constant function;
  - the divide-by-zero quotient constant (all ones).
- One natural sub-module: div_sub_stage. It is a WIDTH+1-bit ripple subtractor built from the team's existing FA/HA cells (b inverted, carry-in 1). It outputs difference and borrow.
- The FSM, registers and restore mux stay in the top module.

Test Plan:
- Reset, then dividend=13, divisor=4 accepted at edge k -> out_valid first high after edge k+4; quotient=3, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 -> quotient=15, remainder=0; dividend=0, divisor=7 -> quotient=0, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=9, divisor=0 -> out_valid high after the accept edge; quotient=4'hF, remainder=9, div_by_zero=1.
- Backpressure: hold out_ready=0 for 3 cycles after 14/3 completes, and toggle in_valid/operands meanwhile -> quotient=4, remainder=2 stable, in_ready=0, no new accept. Then out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset: drive rst_n=0 two cycles into CALC -> next cycle out_valid=0, in_ready=1, outputs 0. A subsequent 10/3 yields 3 rem 1.
- Exhaustive sweep of all 256 operand pairs (WIDTH=4) with random out_ready -> every result matches the reference model, with latency exactly WIDTH edges when divisor≠0.

Source files
------------

// File: rtl/seq_restoring_divider_pkg.sv
// ----------------------------------------------------------------------------
// seq_restoring_divider_pkg
//   Shared definitions for the sequential restoring divider:
//   - div_state_e  : FSM state encoding (IDLE=0, CALC=1, DONE=2)
//   - div_clog2    : constant ceil(log2) used to size the step counter
//   - DBZ_QUOTIENT : all-ones pattern reported as quotient on divide-by-zero
//                    (sliced to the operand width by the user)
// ----------------------------------------------------------------------------
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [63:0] DBZ_QUOTIENT = {64{1'b1}};

  // ceil(log2(value)) for value >= 2; elaboration-time only.
  function automatic int div_clog2(input int value);
    int result;
    int rem_v;
    result = 0;
    rem_v  = value - 1;
    while (rem_v > 0) begin
      result = result + 1;
      rem_v  = rem_v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/div_sub_stage.sv
// ----------------------------------------------------------------------------
// div_sub_stage
//   (WIDTH+1)-bit ripple subtractor a - b, built as a chain of full-adder
//   cells adding a to the inverted b with a carry-in of 1.
//   Ports:
//     a      in  WIDTH+1  shifted partial remainder R'
//     b      in  WIDTH+1  zero-extended divisor {1'b0, D}
//     diff   out WIDTH    low WIDTH bits of the difference
//     borrow out 1        MSB of the (WIDTH+1)-bit difference
//   Because the restoring invariant keeps R' < 2*D, the MSB of the difference
//   is set exactly when a < b, so it serves as the borrow flag. The top cell
//   therefore only needs its sum output.
// ----------------------------------------------------------------------------
module div_sub_stage
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] b_n;
  logic [WIDTH:0] carry;
  logic [WIDTH:0] sum;

  assign b_n      = ~b;
  assign carry[0] = 1'b1;

  genvar i;
  for (i = 0; i < WIDTH; i = i + 1) begin : g_fa
    assign sum[i]       = a[i] ^ b_n[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b_n[i]) | (carry[i] & (a[i] ^ b_n[i]));
  end

  assign sum[WIDTH] = a[WIDTH] ^ b_n[WIDTH] ^ carry[WIDTH];

  assign diff   = sum[WIDTH-1:0];
  assign borrow = sum[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// seq_restoring_divider
//   Unsigned restoring shift-subtract divider, one quotient bit per clock.
//   Ports:
//     clk         in  1      rising-edge clock
//     rst_n       in  1      synchronous active-low reset
//     in_valid    in  1      dividend/divisor valid
//     in_ready    out 1      block can accept operands (IDLE)
//     dividend    in  WIDTH  unsigned numerator
//     divisor     in  WIDTH  unsigned denominator
//     out_valid   out 1      result registers hold a completed result (DONE)
//     out_ready   in  1      consumer takes the result
//     quotient    out WIDTH  floor(dividend/divisor), all ones on /0
//     remainder   out WIDTH  dividend mod divisor, dividend on /0
//     div_by_zero out 1      divisor was zero for this result
//   Latency: result visible WIDTH edges after the accept edge, or right after
//   the accept edge when the divisor is zero.
// ----------------------------------------------------------------------------
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W    = div_clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] DBZ_Q    = DBZ_QUOTIENT[WIDTH-1:0];

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  // The restored remainder is always < D, so its WIDTH+1-th bit is always 0
  // and only the low WIDTH bits are stored; R' is rebuilt WIDTH+1 bits wide.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // R' = {R, Q msb}; trial subtract R' - {0, D}.
  assign r_shift = {r_q, q_q[WIDTH-1]};

  div_sub_stage #(
    .WIDTH (WIDTH)
  ) u_sub (
    .a      (r_shift),
    .b      ({1'b0, d_q}),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  // Restore mux: keep R' on borrow, otherwise take the difference.
  assign r_next = sub_borrow ? r_shift[WIDTH-1:0] : sub_diff;
  assign q_next = {q_q[WIDTH-2:0], ~sub_borrow};

  // Next-state, datapath update and result latch.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == {WIDTH{1'b0}}) begin
            quotient_d  = DBZ_Q;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            q_d     = dividend;
            r_d     = {WIDTH{1'b0}};
            d_d     = divisor;
            cnt_d   = {CNT_W{1'b0}};
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        q_d   = q_next;
        r_d   = r_next;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          quotient_d  = q_next;
          remainder_d = r_next;
          dbz_d       = 1'b0;
          state_d     = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered from the next state so they line up
    // with state_q after the edge.
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  // State, datapath and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= {WIDTH{1'b0}};
      r_q         <= {WIDTH{1'b0}};
      d_q         <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Self-checking bench: a negedge monitor pushes reference results when an
//   operand pair is accepted and pops/compares them at result handoff,
//   including the accept-to-valid latency.
// ----------------------------------------------------------------------------
module tb_seq_restoring_divider;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic prev_ov  = 1'b0;

  seq_restoring_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after edge n, cyc == n.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, got %0d checks, required completion", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    e.acc = acc;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor, sampling on the falling edge what the next rising
  // edge will act on.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          check_eq("spurious_valid", 32'(sb.size()), 32'd1);
        end else begin
          check_eq("latency", cyc - sb[0].acc, sb[0].dbz ? 0 : W);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_result", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check_eq("quotient", 32'(quotient), 32'(e.q));
          check_eq("remainder", 32'(remainder), 32'(e.r));
          check_eq("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_div(dividend, divisor, cyc + 1));
      end
      prev_ov = out_valid;
    end
  end

  // Present one operand pair and hold it until the accept edge has passed.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t = t + 1;
    end
    check_eq("accepted", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Wait for the result handoff; optionally randomise out_ready meanwhile.
  task automatic wait_handoff(input bit rnd);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    while (!done && t < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        t = t + 1;
      end
    end
    check_eq("handoff_seen", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  logic [W-1:0] dir_a [5];
  logic [W-1:0] dir_b [5];

  // Main stimulus.
  initial begin
    int t;
    dir_a = '{4'd13, 4'd15, 4'd0, 4'd5, 4'd9};
    dir_b = '{4'd4,  4'd1,  4'd7, 4'd9, 4'd0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_quotient", 32'(quotient), 32'd0);
    check_eq("rst_remainder", 32'(remainder), 32'd0);
    check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases, including divide-by-zero.
    for (int i = 0; i < 5; i++) begin
      do_op(dir_a[i], dir_b[i]);
      wait_handoff(1'b0);
    end

    // Backpressure: result held, inputs ignored while DONE.
    out_ready = 1'b0;
    do_op(4'd14, 4'd3);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t = t + 1;
    end
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(negedge clk);
      check_eq("bp_quotient", 32'(quotient), 32'd4);
      check_eq("bp_remainder", 32'(remainder), 32'd2);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check_eq("bp_idle_out_valid", 32'(out_valid), 32'd0);
    check_eq("bp_hold_quotient", 32'(quotient), 32'd4);
    check_eq("bp_no_new_accept", 32'(sb.size()), 32'd0);

    // Reset two cycles into CALC abandons the operation.
    do_op(4'd12, 4'd5);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_quotient", 32'(quotient), 32'd0);
    check_eq("mid_rst_remainder", 32'(remainder), 32'd0);
    check_eq("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (6) @(negedge clk);
    check_eq("mid_rst_no_result", 32'(out_valid), 32'd0);
    do_op(4'd10, 4'd3);
    wait_handoff(1'b0);
    check_eq("after_rst_quotient", 32'(quotient), 32'd3);
    check_eq("after_rst_remainder", 32'(remainder), 32'd1);

    // Exhaustive sweep with random out_ready.
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        do_op(W'(a), W'(b));
        wait_handoff(1'b1);
      end
    end

    @(negedge clk);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
